// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} delivered to HI/LO with a registered ready flag.
module div_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);

   // Handshake: ex holds start_i high until it sees ready_o=1, then drops
   // start_i; the result is valid for every cycle ready_o is high.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic [DATA_W-1:0]   dvs_q;
   logic                neg1_q;
   logic                neg2_q;
   logic                signed_q;

   logic [DATA_W-1:0]   abs1;
   logic [DATA_W-1:0]   abs2;
   logic [DATA_W:0]     shifted;
   logic [DATA_W+1:0]   trial;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign stallreq_o = start_i & ~ready_o;

   assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;

   // The partial remainder is always below the divisor, so the shifted value
   // fits DATA_W+1 bits and the extra top bit of trial is the borrow.
   assign shifted = {rem_q, quo_q[DATA_W-1]};
   assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

   assign quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~quo_q + ONE) : quo_q;
   assign rem_fix = (signed_q && neg1_q) ? (~rem_q + ONE) : rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_BYZERO: begin
            // Divide-by-zero spends two edges here so ready_o rises two
            // edges after the accept edge.
            if (annul_i) begin
               state_d = S_IDLE;
            end else if (cnt_q != '0) begin
               state_d = S_END;
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_END;
            end
         end
         S_END: begin
            if (!start_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         signed_q <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               cnt_q    <= '0;
               if (state_d == S_ON) begin
                  rem_q    <= '0;
                  quo_q    <= abs1;
                  dvs_q    <= abs2;
                  neg1_q   <= opdata1_i[DATA_W-1];
                  neg2_q   <= opdata2_i[DATA_W-1];
                  signed_q <= signed_div_i;
               end
            end
            S_BYZERO: begin
               cnt_q <= cnt_q + 1'b1;
               if (state_d == S_END) begin
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            S_ON: begin
               if (!annul_i) begin
                  if (cnt_q == CNT_LAST) begin
                     result_o <= {rem_fix, quo_fix};
                     ready_o  <= 1'b1;
                  end else begin
                     if (!trial[DATA_W+1]) begin
                        rem_q <= trial[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                     end else begin
                        rem_q <= shifted[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                     end
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_END: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
            default: begin
               result_o <= '0;
               ready_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases from the divider's behaviour
// plus random operands checked against a plain-arithmetic reference.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int total;
   int bad;

   div_seq dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Drives one request and holds start_i until ready_o. lat is the number of
   // edges after the accept edge (-1 on timeout). Must be entered #1 after an edge.
   task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output bit stall_ok);
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      stall_ok     = 1'b1;
      lat          = -1;
      #1;
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         if (ready_o === 1'b1) begin
            lat = k;
            break;
         end
         if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      end
      if (stallreq_o !== 1'b0) stall_ok = 1'b0;
      res = result_o;
   endtask

   task automatic drop_start(output logic rdy, output logic [63:0] res);
      start_i = 1'b0;
      annul_i = 1'b0;
      @(posedge clk); #1;
      rdy = ready_o;
      res = result_o;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: result=%h ready=%b stall=%b, required 0/0/0", result_o, ready_o, stallreq_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ready_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b, required 0", ready_o);
      end
   endtask

   task automatic test_basic;
      logic [63:0] res;
      logic [63:0] r2;
      logic        rdy;
      int          lat;
      bit          sok;
      do_div(1'b0, 32'd100, 32'd7, res, lat, sok);
      total++;
      if (lat !== 33) begin
         bad++;
         $display("FAIL basic_latency: got %0d edges, required 33", lat);
      end
      total++;
      if (res !== {32'd2, 32'd14}) begin
         bad++;
         $display("FAIL basic_result: got %h, required %h", res, {32'd2, 32'd14});
      end
      total++;
      if (!sok) begin
         bad++;
         $display("FAIL basic_stallreq: stall did not track busy, got 0 required 1");
      end
      // Result holds in END while start_i stays high, and annul_i is ignored there.
      annul_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      annul_i = 1'b0;
      total++;
      if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
         bad++;
         $display("FAIL end_hold: ready=%b result=%h, required 1 and %h", ready_o, result_o, {32'd2, 32'd14});
      end
      drop_start(rdy, r2);
      total++;
      if (rdy !== 1'b0 || r2 !== 64'd0) begin
         bad++;
         $display("FAIL end_release: ready=%b result=%h, required 0 and 0", rdy, r2);
      end
   endtask

   task automatic test_signed;
      logic [63:0] res;
      logic [63:0] r2;
      logic        rdy;
      int          lat;
      bit          sok;
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, sok);
      total++;
      if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33) begin
         bad++;
         $display("FAIL signed_neg7_2: got %h lat %0d, required %h lat 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      end
      drop_start(rdy, r2);
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, sok);
      total++;
      if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
         bad++;
         $display("FAIL signed_7_neg2: got %h, required %h", res, {32'h0000_0001, 32'hFFFF_FFFD});
      end
      drop_start(rdy, r2);
   endtask

   task automatic test_byzero;
      logic [63:0] res;
      logic [63:0] r2;
      logic        rdy;
      int          lat;
      bit          sok;
      do_div(1'b1, 32'h1234_5678, 32'd0, res, lat, sok);
      total++;
      if (lat !== 2 || res !== 64'd0) begin
         bad++;
         $display("FAIL byzero: got lat %0d result %h, required lat 2 result 0", lat, res);
      end
      drop_start(rdy, r2);
      total++;
      if (rdy !== 1'b0) begin
         bad++;
         $display("FAIL byzero_release: ready=%b, required 0", rdy);
      end
   endtask

   task automatic test_boundary;
      logic [63:0] res;
      logic [63:0] r2;
      logic        rdy;
      int          lat;
      bit          sok;
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sok);
      total++;
      if (res !== {32'd0, 32'h8000_0000}) begin
         bad++;
         $display("FAIL min_div_neg1: got %h, required %h", res, {32'd0, 32'h8000_0000});
      end
      drop_start(rdy, r2);
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat, sok);
      total++;
      if (res !== {32'd0, 32'hFFFF_FFFF}) begin
         bad++;
         $display("FAIL max_div_1: got %h, required %h", res, {32'd0, 32'hFFFF_FFFF});
      end
      drop_start(rdy, r2);
      do_div(1'b0, 32'd5, 32'd9, res, lat, sok);
      total++;
      if (res !== {32'd5, 32'd0}) begin
         bad++;
         $display("FAIL small_div_big: got %h, required %h", res, {32'd5, 32'd0});
      end
      drop_start(rdy, r2);
   endtask

   task automatic test_random;
      logic [63:0] res;
      logic [63:0] r2;
      logic [63:0] exp;
      logic [31:0] a;
      logic [31:0] b;
      logic        rdy;
      bit          sd;
      int          lat;
      int          exp_lat;
      bit          sok;
      for (int i = 0; i < 24; i++) begin
         sd = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = -($urandom_range(1, 15));
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         exp     = ref_div(sd, a, b);
         exp_lat = (b == 32'd0) ? 2 : 33;
         do_div(sd, a, b, res, lat, sok);
         total++;
         if (res !== exp || lat !== exp_lat || !sok) begin
            bad++;
            $display("FAIL random_%0d: sd=%0d %h/%h got %h lat %0d stall_ok %0d, required %h lat %0d stall_ok 1",
                     i, sd, a, b, res, lat, sok, exp, exp_lat);
         end
         drop_start(rdy, r2);
      end
   endtask

   task automatic test_annul;
      logic [63:0] res;
      int          lat;
      bit          sok;
      bit          seen;
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL annul_no_ready: ready rose after annul, got 1 required 0");
      end
      do_div(1'b0, 32'd100, 32'd7, res, lat, sok);
      total++;
      if (res !== {32'd2, 32'd14} || lat !== 33) begin
         bad++;
         $display("FAIL annul_recover: got %h lat %0d, required %h lat 33", res, lat, {32'd2, 32'd14});
      end
      start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [63:0] res;
      int          lat;
      bit          sok;
      bit          seen;
      signed_div_i = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      @(posedge clk); #1;
      repeat (20) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (result_o !== 64'd0 || ready_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_on: result=%h ready=%b, required 0/0", result_o, ready_o);
      end
      start_i = 1'b0;
      #2;
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_no_ready: ready rose after reset release, got 1 required 0");
      end
      // Reset while a finished result is being held must clear it at once.
      do_div(1'b0, 32'd1000, 32'd3, res, lat, sok);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (result_o !== 64'd0 || ready_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_end: result=%h ready=%b, required 0/0 (held %h)", result_o, ready_o, res);
      end
      start_i = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_signed();
      test_byzero();
      test_boundary();
      test_random();
      test_annul();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
